// File: rtl/i2c_apb_arb.sv
// ---------------------------------------------------------------------------
// i2c_apb_arb
//
// Two-port APB arbiter in front of the single i2c_core APB slave port.
// One requester is granted at a time. Its transfer is replayed to the slave
// as a clean zero-wait SETUP/ACCESS pair. The result (prdata, pready,
// pslverr) goes back to the granted requester only.
//
// Parameters
//   ADDR_W      slave address width (1..32); requester address bits above
//               ADDR_W-1 must be zero, otherwise the transfer ends in error
//               without touching the slave
//   FIXED_PRIO  0 = round-robin on a tie, 1 = port 0 always wins a tie
//
// Ports
//   pclk, prst_n             clock, synchronous active-low reset
//   m0_* / m1_*              APB completer-side ports facing requesters 0/1
//                            (psel, penable, pwrite, paddr, pwdata in;
//                             prdata, pready, pslverr out)
//   s_*                      APB requester-side port facing i2c_core
//                            (psel, penable, pwrite, paddr, pwdata out;
//                             prdata in, zero wait states)
//
// All outputs are registered. A transfer takes four cycles:
// IDLE (grant) -> SETUP -> ACCESS -> DONE (pready pulse).
// An out-of-range address takes two cycles: IDLE -> DONE (pslverr).
// ---------------------------------------------------------------------------
module i2c_apb_arb #(
    parameter int ADDR_W     = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              pclk,
    input  logic              prst_n,

    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [31:0]       m0_paddr,
    input  logic [31:0]       m0_pwdata,
    output logic [31:0]       m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,

    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [31:0]       m1_paddr,
    input  logic [31:0]       m1_pwdata,
    output logic [31:0]       m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,

    output logic              s_psel,
    output logic              s_penable,
    output logic              s_pwrite,
    output logic [ADDR_W-1:0] s_paddr,
    output logic [31:0]       s_pwdata,
    input  logic [31:0]       s_prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic        grant;       // port currently in service
    logic        last_grant;  // port granted most recently, for round-robin
    logic        wr_flag;     // granted transfer is a write

    logic        pick;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        addr_bad;

    // Mask of the requester address bits that must be zero. Built in 64 bits
    // so that ADDR_W = 32 yields an empty mask instead of a shift overflow.
    localparam logic [63:0] LOW_ONES  = (64'd1 << ADDR_W) - 64'd1;
    localparam logic [31:0] HIGH_MASK = ~LOW_ONES[31:0];

    // penable carries no information the arbiter needs: a request is psel
    // seen in IDLE, and the slave-side phases are generated locally.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // Winner of the current IDLE sample. On a tie, round-robin hands the
    // grant to whichever port did not have it last time.
    always_comb begin
        pick = 1'b0;
        if (m0_psel && m1_psel) begin
            pick = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else if (m1_psel) begin
            pick = 1'b1;
        end
    end

    assign sel_write = pick ? m1_pwrite : m0_pwrite;
    assign sel_addr  = pick ? m1_paddr  : m0_paddr;
    assign sel_wdata = pick ? m1_pwdata : m0_pwdata;
    assign addr_bad  = |(sel_addr & HIGH_MASK);

    // Sequencer. Every output is assigned together with the state it
    // belongs to, so outputs line up with the state register. The waiting
    // port never reaches the slave side because the s_* fields are only
    // loaded from the granted port at the moment of the grant.
    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wr_flag    <= 1'b0;
            s_psel     <= 1'b0;
            s_penable  <= 1'b0;
            s_pwrite   <= 1'b0;
            s_paddr    <= '0;
            s_pwdata   <= '0;
            m0_prdata  <= '0;
            m0_pready  <= 1'b0;
            m0_pslverr <= 1'b0;
            m1_prdata  <= '0;
            m1_pready  <= 1'b0;
            m1_pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        grant      <= pick;
                        last_grant <= pick;
                        wr_flag    <= sel_write;
                        if (addr_bad) begin
                            // Refuse without a slave access; the error is
                            // reported in the very next cycle.
                            state <= DONE;
                            if (pick) begin
                                m1_pready  <= 1'b1;
                                m1_pslverr <= 1'b1;
                                m1_prdata  <= '0;
                            end else begin
                                m0_pready  <= 1'b1;
                                m0_pslverr <= 1'b1;
                                m0_prdata  <= '0;
                            end
                        end else begin
                            state     <= SETUP;
                            s_psel    <= 1'b1;
                            s_penable <= 1'b0;
                            s_pwrite  <= sel_write;
                            s_paddr   <= sel_addr[ADDR_W-1:0];
                            s_pwdata  <= sel_wdata;
                        end
                    end
                end

                SETUP: begin
                    s_penable <= 1'b1;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    // Slave has zero wait states: its read data is valid at
                    // the end of this cycle. Writes return zero upstream.
                    s_psel    <= 1'b0;
                    s_penable <= 1'b0;
                    state     <= DONE;
                    if (grant) begin
                        m1_pready  <= 1'b1;
                        m1_pslverr <= 1'b0;
                        m1_prdata  <= wr_flag ? 32'd0 : s_prdata;
                    end else begin
                        m0_pready  <= 1'b1;
                        m0_pslverr <= 1'b0;
                        m0_prdata  <= wr_flag ? 32'd0 : s_prdata;
                    end
                end

                DONE: begin
                    m0_prdata  <= '0;
                    m0_pready  <= 1'b0;
                    m0_pslverr <= 1'b0;
                    m1_prdata  <= '0;
                    m1_pready  <= 1'b0;
                    m1_pslverr <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_arb.sv
// ---------------------------------------------------------------------------
// tb_i2c_apb_arb
//
// Self-checking bench for i2c_apb_arb. Two instances share one set of
// inputs: round-robin (FIXED_PRIO=0) and fixed priority (FIXED_PRIO=1);
// use_fp selects which one is checked.
//
// The reference model is a timeline: when the arbiter is free and someone
// requests, it picks the winner from the tie rule and writes the expected
// outputs of the next few cycles into a per-cycle table. Every cycle, every
// output is compared against that table.
// ---------------------------------------------------------------------------
module tb_i2c_apb_arb;

    localparam int ADDR_W = 8;
    localparam int MAXC   = 4096;

    logic        pclk;
    logic        prst_n;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic [31:0] m0_paddr, m0_pwdata;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m1_paddr, m1_pwdata;
    logic [31:0] s_prdata;

    logic [31:0]       rr_m0_prdata, rr_m1_prdata, rr_s_pwdata;
    logic              rr_m0_pready, rr_m0_pslverr, rr_m1_pready, rr_m1_pslverr;
    logic              rr_s_psel, rr_s_penable, rr_s_pwrite;
    logic [ADDR_W-1:0] rr_s_paddr;
    logic [31:0]       fp_m0_prdata, fp_m1_prdata, fp_s_pwdata;
    logic              fp_m0_pready, fp_m0_pslverr, fp_m1_pready, fp_m1_pslverr;
    logic              fp_s_psel, fp_s_penable, fp_s_pwrite;
    logic [ADDR_W-1:0] fp_s_paddr;

    i2c_apb_arb #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b0)) dut_rr (
        .pclk(pclk), .prst_n(prst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_prdata(rr_m0_prdata), .m0_pready(rr_m0_pready), .m0_pslverr(rr_m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_prdata(rr_m1_prdata), .m1_pready(rr_m1_pready), .m1_pslverr(rr_m1_pslverr),
        .s_psel(rr_s_psel), .s_penable(rr_s_penable), .s_pwrite(rr_s_pwrite),
        .s_paddr(rr_s_paddr), .s_pwdata(rr_s_pwdata), .s_prdata(s_prdata)
    );

    i2c_apb_arb #(.ADDR_W(ADDR_W), .FIXED_PRIO(1'b1)) dut_fp (
        .pclk(pclk), .prst_n(prst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata),
        .m0_prdata(fp_m0_prdata), .m0_pready(fp_m0_pready), .m0_pslverr(fp_m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata),
        .m1_prdata(fp_m1_prdata), .m1_pready(fp_m1_pready), .m1_pslverr(fp_m1_pslverr),
        .s_psel(fp_s_psel), .s_penable(fp_s_penable), .s_pwrite(fp_s_pwrite),
        .s_paddr(fp_s_paddr), .s_pwdata(fp_s_pwdata), .s_prdata(s_prdata)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Expected outputs for one cycle.
    typedef struct {
        bit          zero_all;
        bit          psel;
        bit          pen;
        bit          pwr;
        bit [7:0]    addr;
        bit [31:0]   wdata;
        bit          rdy0;
        bit          rdy1;
        bit          err;
        bit          rwr;
        int          rcyc;
    } exp_t;

    typedef struct {
        int          port;
        bit          wr;
        bit [31:0]   addr;
        bit [31:0]   wdata;
        bit [31:0]   srd;
        int          lat;
        bit          err;
        bit [31:0]   rdata;
    } vec_t;

    exp_t        exp_tab[MAXC];
    bit [31:0]   rdat_drv[MAXC];
    int          cyc;
    int          checks;
    int          errors;

    // Timeline model state.
    int          free_cyc;
    bit          last_port;

    // Requester models.
    bit          rst_drive;
    bit          use_fp;
    bit          act[2], fin[2], drp[2], mwr[2];
    bit [31:0]   maddr[2], mwd[2];
    int          mstart[2];
    int          prob[2];
    bit          allow_bad;
    bit          frc[2], frc_wr[2], frc_drp[2];
    bit [31:0]   frc_addr[2], frc_wd[2];
    bit          fixed_srd_en;
    bit [31:0]   fixed_srd;

    // Observed completions, taken from the checked DUT.
    int          obs_port[$];
    int          obs_cyc[$];
    bit          obs_err[$];
    bit [31:0]   obs_rd[$];

    vec_t        vecs[6];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=0x%0h want=0x%0h", nm, cyc, a, e);
        end
    endtask

    task automatic clear_exp(input int k);
        exp_tab[k].zero_all = 1'b0;
        exp_tab[k].psel     = 1'b0;
        exp_tab[k].pen      = 1'b0;
        exp_tab[k].pwr      = 1'b0;
        exp_tab[k].addr     = '0;
        exp_tab[k].wdata    = '0;
        exp_tab[k].rdy0     = 1'b0;
        exp_tab[k].rdy1     = 1'b0;
        exp_tab[k].err      = 1'b0;
        exp_tab[k].rwr      = 1'b0;
        exp_tab[k].rcyc     = 0;
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic        o_sp, o_se, o_sw, o_r0, o_e0, o_r1, o_e1;
        logic [31:0] o_sa, o_sd, o_d0, o_d1;
        logic [31:0] want0, want1;
        e    = exp_tab[cyc];
        o_sp = use_fp ? fp_s_psel    : rr_s_psel;
        o_se = use_fp ? fp_s_penable : rr_s_penable;
        o_sw = use_fp ? fp_s_pwrite  : rr_s_pwrite;
        o_sa = use_fp ? 32'(fp_s_paddr) : 32'(rr_s_paddr);
        o_sd = use_fp ? fp_s_pwdata  : rr_s_pwdata;
        o_r0 = use_fp ? fp_m0_pready  : rr_m0_pready;
        o_e0 = use_fp ? fp_m0_pslverr : rr_m0_pslverr;
        o_d0 = use_fp ? fp_m0_prdata  : rr_m0_prdata;
        o_r1 = use_fp ? fp_m1_pready  : rr_m1_pready;
        o_e1 = use_fp ? fp_m1_pslverr : rr_m1_pslverr;
        o_d1 = use_fp ? fp_m1_prdata  : rr_m1_prdata;

        if (e.zero_all) begin
            chk("rst_s_pwrite", 32'(o_sw), 32'd0);
            chk("rst_s_paddr", o_sa, 32'd0);
            chk("rst_s_pwdata", o_sd, 32'd0);
        end
        chk("s_psel", 32'(o_sp), 32'(e.psel));
        chk("s_penable", 32'(o_se), 32'(e.pen));
        if (e.psel) begin
            chk("s_pwrite", 32'(o_sw), 32'(e.pwr));
            chk("s_paddr", o_sa, 32'(e.addr));
            chk("s_pwdata", o_sd, e.wdata);
        end
        want0 = (e.rdy0 && !e.err && !e.rwr) ? rdat_drv[e.rcyc] : 32'd0;
        want1 = (e.rdy1 && !e.err && !e.rwr) ? rdat_drv[e.rcyc] : 32'd0;
        chk("m0_pready", 32'(o_r0), 32'(e.rdy0));
        chk("m0_pslverr", 32'(o_e0), 32'(e.rdy0 & e.err));
        chk("m0_prdata", o_d0, want0);
        chk("m1_pready", 32'(o_r1), 32'(e.rdy1));
        chk("m1_pslverr", 32'(o_e1), 32'(e.rdy1 & e.err));
        chk("m1_prdata", o_d1, want1);

        if (o_r0 === 1'b1) begin
            obs_port.push_back(0); obs_cyc.push_back(cyc);
            obs_err.push_back(o_e0); obs_rd.push_back(o_d0);
        end
        if (o_r1 === 1'b1) begin
            obs_port.push_back(1); obs_cyc.push_back(cyc);
            obs_err.push_back(o_e1); obs_rd.push_back(o_d1);
        end
    endtask

    task automatic applyStimulus();
        bit [31:0] a;
        for (int p = 0; p < 2; p++) begin
            if (fin[p]) begin
                act[p] = 1'b0;
                fin[p] = 1'b0;
            end
            if (!rst_drive) begin
                act[p] = 1'b0;
            end else if (!act[p]) begin
                if (frc[p]) begin
                    act[p] = 1'b1; mwr[p] = frc_wr[p]; maddr[p] = frc_addr[p];
                    mwd[p] = frc_wd[p]; drp[p] = frc_drp[p]; mstart[p] = cyc;
                    frc[p] = 1'b0;
                end else if (prob[p] > 0 && int'($urandom_range(99)) < prob[p]) begin
                    a = $urandom_range(255);
                    if (allow_bad && $urandom_range(7) == 0) begin
                        a = $urandom;
                        if (a[31:8] == 24'd0) a[8] = 1'b1;
                    end
                    act[p] = 1'b1; mwr[p] = $urandom_range(1); maddr[p] = a;
                    mwd[p] = $urandom; mstart[p] = cyc;
                    drp[p] = allow_bad && ($urandom_range(15) == 0);
                end
            end
            if (act[p] && ((p == 0) ? exp_tab[cyc].rdy0 : exp_tab[cyc].rdy1)) fin[p] = 1'b1;
        end
        prst_n     = rst_drive;
        m0_psel    = act[0] && !(drp[0] && cyc > mstart[0]);
        m0_penable = m0_psel && cyc > mstart[0];
        m0_pwrite  = mwr[0];
        m0_paddr   = maddr[0];
        m0_pwdata  = mwd[0];
        m1_psel    = act[1] && !(drp[1] && cyc > mstart[1]);
        m1_penable = m1_psel && cyc > mstart[1];
        m1_pwrite  = mwr[1];
        m1_paddr   = maddr[1];
        m1_pwdata  = mwd[1];
        s_prdata   = fixed_srd_en ? fixed_srd : $urandom;
        rdat_drv[cyc] = s_prdata;
    endtask

    // Decision taken at the clock edge that ends cycle 'cyc'.
    task automatic model_edge();
        int        w;
        bit [31:0] a;
        if (!prst_n) begin
            for (int k = 1; k <= 4; k++) clear_exp(cyc + k);
            exp_tab[cyc + 1].zero_all = 1'b1;
            free_cyc  = cyc + 1;
            last_port = 1'b1;
            return;
        end
        if (cyc >= free_cyc && (m0_psel || m1_psel)) begin
            if (m0_psel && m1_psel) w = use_fp ? 0 : (last_port ? 0 : 1);
            else w = m1_psel ? 1 : 0;
            last_port = (w == 1);
            a = (w == 1) ? m1_paddr : m0_paddr;
            if (a >= 32'd256) begin
                if (w == 1) exp_tab[cyc + 1].rdy1 = 1'b1; else exp_tab[cyc + 1].rdy0 = 1'b1;
                exp_tab[cyc + 1].err = 1'b1;
                free_cyc = cyc + 2;
            end else begin
                for (int k = 1; k <= 2; k++) begin
                    exp_tab[cyc + k].psel  = 1'b1;
                    exp_tab[cyc + k].pen   = (k == 2);
                    exp_tab[cyc + k].pwr   = (w == 1) ? m1_pwrite : m0_pwrite;
                    exp_tab[cyc + k].addr  = a[7:0];
                    exp_tab[cyc + k].wdata = (w == 1) ? m1_pwdata : m0_pwdata;
                end
                if (w == 1) exp_tab[cyc + 3].rdy1 = 1'b1; else exp_tab[cyc + 3].rdy0 = 1'b1;
                exp_tab[cyc + 3].rwr  = (w == 1) ? m1_pwrite : m0_pwrite;
                exp_tab[cyc + 3].rcyc = cyc + 2;
                free_cyc = cyc + 4;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            cyc++;
            if (cyc >= MAXC - 8) begin
                $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 8);
                $fatal(1, "[TB] cycle budget exhausted");
            end
            checkOutput();
            applyStimulus();
            model_edge();
        end
    endtask

    task automatic do_reset(input int n);
        rst_drive = 1'b0;
        run_cycles(n);
        rst_drive = 1'b1;
    endtask

    task automatic force_txn(input int p, input bit wr, input bit [31:0] a,
                             input bit [31:0] wd, input bit dr);
        frc[p] = 1'b1; frc_wr[p] = wr; frc_addr[p] = a; frc_wd[p] = wd; frc_drp[p] = dr;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, n0, cnt;
        checks = 0; errors = 0; cyc = 0;
        use_fp = 1'b0; rst_drive = 1'b0; allow_bad = 1'b0;
        fixed_srd_en = 1'b0; fixed_srd = '0;
        free_cyc = 0; last_port = 1'b1;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; fin[p] = 0; drp[p] = 0; mwr[p] = 0; maddr[p] = 0; mwd[p] = 0;
            mstart[p] = 0; prob[p] = 0; frc[p] = 0; frc_wr[p] = 0; frc_drp[p] = 0;
            frc_addr[p] = 0; frc_wd[p] = 0;
        end
        prst_n = 1'b0;
        m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pwdata = 0;
        m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pwdata = 0;
        s_prdata = 0;
        for (int k = 0; k < MAXC; k++) begin
            clear_exp(k);
            rdat_drv[k] = '0;
        end
        model_edge();

        // {port, write, addr, wdata, slave rdata, latency, pslverr, prdata}
        vecs[0] = '{0, 1'b1, 32'h0000_0004, 32'h0000_00A5, 32'hDEAD_BEEF, 3, 1'b0, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_003C, 3, 1'b0, 32'h3C};
        vecs[2] = '{0, 1'b0, 32'h0000_00FF, 32'h0,         32'h1234_5678, 3, 1'b0, 32'h1234_5678};
        vecs[3] = '{0, 1'b0, 32'h0000_0100, 32'h0,         32'h5555_AAAA, 1, 1'b1, 32'h0};
        vecs[4] = '{1, 1'b1, 32'h8000_0000, 32'h0000_0077, 32'h0000_0001, 1, 1'b1, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 3, 1'b0, 32'hFFFF_FFFF};

        $display("[TB] reset");
        run_cycles(3);
        rst_drive = 1'b1;

        $display("[TB] single transfer table");
        fixed_srd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fixed_srd = vecs[i].srd;
            base = obs_port.size();
            force_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
            run_cycles(7);
            chk($sformatf("v%0d_completions", i), 32'(obs_port.size() - base), 32'd1);
            if (obs_port.size() > base) begin
                chk($sformatf("v%0d_port", i), 32'(obs_port[base]), 32'(vecs[i].port));
                chk($sformatf("v%0d_latency", i), 32'(obs_cyc[base] - mstart[vecs[i].port]),
                    32'(vecs[i].lat));
                chk($sformatf("v%0d_pslverr", i), 32'(obs_err[base]), 32'(vecs[i].err));
                chk($sformatf("v%0d_prdata", i), obs_rd[base], vecs[i].rdata);
            end
        end

        $display("[TB] psel dropped during setup");
        fixed_srd = 32'h0000_5A5A;
        base = obs_port.size();
        force_txn(1, 1'b0, 32'h0000_0033, 32'h0, 1'b1);
        run_cycles(7);
        chk("drop_completions", 32'(obs_port.size() - base), 32'd1);
        if (obs_port.size() > base) begin
            chk("drop_latency", 32'(obs_cyc[base] - mstart[1]), 32'd3);
            chk("drop_prdata", obs_rd[base], 32'h0000_5A5A);
        end

        $display("[TB] reset during access");
        force_txn(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        run_cycles(2);
        base = obs_port.size();
        rst_drive = 1'b0;
        run_cycles(2);
        rst_drive = 1'b1;
        run_cycles(2);
        chk("abort_no_pready", 32'(obs_port.size() - base), 32'd0);
        force_txn(0, 1'b0, 32'h0000_0021, 32'h0, 1'b0);
        force_txn(1, 1'b0, 32'h0000_0022, 32'h0, 1'b0);
        base = obs_port.size();
        run_cycles(10);
        chk("abort_completions", 32'(obs_port.size() - base), 32'd2);
        if (obs_port.size() > base) chk("abort_first_port", 32'(obs_port[base]), 32'd0);

        $display("[TB] round-robin with both requesting");
        fixed_srd_en = 1'b0;
        do_reset(2);
        base = obs_port.size();
        n0 = cyc + 1;
        prob[0] = 100; prob[1] = 100;
        for (int k = 0; k < 60 && obs_port.size() < base + 8; k++) run_cycles(1);
        chk("rr_completions", 32'(obs_port.size() - base), 32'd8);
        if (obs_port.size() >= base + 8) begin
            for (int j = 0; j < 8; j++) chk($sformatf("rr_order%0d", j), 32'(obs_port[base + j]), 32'(j % 2));
            chk("rr_first_latency", 32'(obs_cyc[base] - n0), 32'd3);
            chk("rr_second_latency", 32'(obs_cyc[base + 1] - n0), 32'd7);
        end
        prob[0] = 0; prob[1] = 0;
        run_cycles(8);

        $display("[TB] fixed priority with both requesting");
        do_reset(2);
        use_fp = 1'b1;
        do_reset(1);
        base = obs_port.size();
        prob[0] = 100; prob[1] = 100;
        run_cycles(30);
        prob[0] = 0; prob[1] = 0;
        cnt = 0;
        for (int j = base; j < obs_port.size(); j++) if (obs_port[j] != 0) cnt++;
        chk("fp_port1_grants", 32'(cnt), 32'd0);
        chk("fp_enough_grants", 32'(obs_port.size() - base >= 6), 32'd1);
        run_cycles(8);

        $display("[TB] random traffic, round-robin");
        do_reset(2);
        use_fp = 1'b0;
        do_reset(1);
        allow_bad = 1'b1;
        prob[0] = 30; prob[1] = 30;
        run_cycles(500);
        prob[0] = 0; prob[1] = 0;
        run_cycles(10);

        $display("[TB] random traffic, fixed priority");
        do_reset(2);
        use_fp = 1'b1;
        do_reset(1);
        prob[0] = 35; prob[1] = 50;
        run_cycles(250);
        prob[0] = 0; prob[1] = 0;
        run_cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_apb_arb.md
Name: i2c_apb_arb

Overview:
- Two-port APB arbiter that shares the single i2c_core APB slave port between two APB requesters.
- Typical requesters: the existing apb_master (port 0) and a second master such as a CPU bridge or DMA (port 1).
- Grants one requester at a time (round-robin or fixed priority), replays its transfer to the slave as a clean zero-wait APB access, and returns read data and pready/pslverr to the granted requester.
- Sits between the masters and i2c_core inside i2c_u.

Parameters:
ADDR_W, 8, slave address width; m*_paddr bits above ADDR_W-1 must be zero.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a tie.

Ports:
pclk  in  1  clock
prst_n  in  1  reset; synchronous, active-low
m0_psel  in  1  port 0 APB select
m0_penable  in  1  port 0 APB enable
m0_pwrite  in  1  port 0 write/read
m0_paddr  in  32  port 0 address
m0_pwdata  in  32  port 0 write data
m0_prdata  out  32  port 0 read data, valid while m0_pready=1
m0_pready  out  1  port 0 transfer complete, 1-cycle pulse
m0_pslverr  out  1  port 0 error, valid with m0_pready
m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_prdata, m1_pready, m1_pslverr  same as port 0, for port 1
s_psel  out  1  slave select
s_penable  out  1  slave enable
s_pwrite  out  1  slave write
s_paddr  out  ADDR_W  slave address
s_pwdata  out  32  slave write data
s_prdata  in  32  slave read data; slave has zero wait states

Behaviour:
- All outputs are registered. When prst_n=0 at a clock edge, every output goes to 0, state goes to IDLE and last_grant goes to 1, so port 0 wins the first tie.
- Request: port n is requesting when mn_psel=1, sampled in IDLE only. Requesters hold psel/penable/pwrite/paddr/pwdata stable until they see pready=1 (standard APB).
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both request, FIXED_PRIO=1: grant port 0.
  - Both request, FIXED_PRIO=0: grant the port not equal to last_grant.
  - On grant: latch grant, pwrite, paddr[ADDR_W-1:0], pwdata; update last_grant.
  - If granted paddr[31:ADDR_W] != 0: go to DONE with the error flag set and perform no slave access. Otherwise go to SETUP.
- SETUP: s_psel=1, s_penable=0, with latched s_pwrite/s_paddr/s_pwdata. Next state ACCESS.
- ACCESS: s_psel=1, s_penable=1. Capture s_prdata at the end of this cycle (captured for writes too). Next state DONE.
- DONE:
  - Granted port gets pready=1 and prdata = captured data (0 on error or write), with pslverr = error flag.
  - The other port's pready/pslverr stay 0 and its prdata stays 0.
  - s_psel=0, s_penable=0. Next state IDLE.
- Latency:
  - Request sampled in IDLE at cycle N: slave setup at N+1, slave access at N+2, pready at N+3.
  - Error path: pready and pslverr at N+1.
  - Back-to-back: the next grant is sampled at N+4. Minimum 4 cycles per transfer.
- Fairness: with both ports continuously requesting and FIXED_PRIO=0, grants strictly alternate 0,1,0,1,...
- Port n request arriving while the other port is in service: held off (pready=0) until IDLE. No slave signal ever reflects the waiting port.
- Requester drops psel during its SETUP/ACCESS (protocol violation): the slave transfer completes unchanged and pready still pulses. The arbiter does not abort.
- Slave outputs hold their last values between transfers except s_psel/s_penable, which are 0 outside SETUP/ACCESS.
- Reset asserted mid-transfer: slave psel/penable drop to 0 at that edge, no pready is issued, and the pending transfer is lost.

Test Plan:
- Reset then single write: m0 write paddr=0x04, pwdata=0xA5 at cycle N -> s_psel=1/s_penable=0 at N+1; s_penable=1, s_paddr=0x04, s_pwdata=0xA5, s_pwrite=1 at N+2; m0_pready=1, m0_pslverr=0 at N+3.
- Single read: m1 read paddr=0x10 with s_prdata=0x0000003C -> m1_prdata=0x3C with m1_pready=1 at N+3; m0_pready stays 0 throughout.
- Simultaneous requests, FIXED_PRIO=0, first after reset: m0 serviced first (pready at N+3), m1 granted at N+4 (pready at N+7). Continuous requests for 8 transfers give grant order 0,1,0,1,0,1,0,1.
- FIXED_PRIO=1 with both continuously requesting -> only port 0 is serviced; port 1 is never granted while m0_psel=1.
- Out-of-range address: m0 paddr=0x100 -> no s_psel pulse; m0_pready=1, m0_pslverr=1, m0_prdata=0 at N+1.
- prst_n=0 asserted in the ACCESS cycle -> next edge: s_psel=0, s_penable=0, no pready on either port. After release, simultaneous requests grant port 0 first.
